// File: rtl/uart_frame_loader.sv
// Hunts for SYNC_BYTE, writes DEPTH payload bytes to RAM port A, then holds the frame until frame_ack.
// Define CHECKSUM_EN to expect a trailing XOR checksum byte, checked in an extra CHECK state.
module uart_frame_loader #(
    parameter int         ADDR_WIDTH = 3,
    parameter int         DEPTH      = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  frame_ack,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_din,
    output logic                  frame_ready,
    output logic                  overrun,
    output logic                  timeout,
    output logic                  chk_err
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, LOAD, CHECK, FULL} state_t;
`else
    typedef enum logic [1:0] {HUNT, LOAD, FULL} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_din_q, ram_din_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
`ifdef CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
    logic                  chk_err_q, chk_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        frame_ready_d = frame_ready_q;
        overrun_d     = overrun_q;
        timeout_d     = 1'b0;
`ifdef CHECKSUM_EN
        xor_d         = xor_q;
        chk_err_d     = chk_err_q;
`endif
        case (state_q)
            HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = LOAD;
                    count_d = '0;
                    timer_d = '0;
`ifdef CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            LOAD: begin
                // A received byte always beats the timer, even on its final idle cycle.
                if (rx_valid) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = count_q[ADDR_WIDTH-1:0];
                    ram_din_d  = rx_data;
                    count_d    = count_q + CNT_ONE;
                    timer_d    = '0;
`ifdef CHECKSUM_EN
                    xor_d      = xor_q ^ rx_data;
                    if (count_q == CNT_LAST) state_d = CHECK;
`else
                    if (count_q == CNT_LAST) state_d = FULL;
`endif
                end else if (timer_q == TMR_LAST) begin
                    state_d   = HUNT;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    state_d       = FULL;
                    timer_d       = '0;
                    frame_ready_d = 1'b1;
                    chk_err_d     = (rx_data != xor_q);
                end else if (timer_q == TMR_LAST) begin
                    state_d   = HUNT;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
`endif
            FULL: begin
                if (frame_ack) begin
                    state_d       = HUNT;
                    frame_ready_d = 1'b0;
                    overrun_d     = 1'b0;
`ifdef CHECKSUM_EN
                    chk_err_d     = 1'b0;
`endif
                end else begin
                    frame_ready_d = 1'b1;
                    if (rx_valid) overrun_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            count_q       <= '0;
            timer_q       <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q         <= '0;
            chk_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
`ifdef CHECKSUM_EN
            xor_q         <= xor_d;
            chk_err_q     <= chk_err_d;
`endif
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign frame_ready = frame_ready_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
`ifdef CHECKSUM_EN
    assign chk_err     = chk_err_q;
`else
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized bench for uart_frame_loader: a cycle-stamped event model of the frame protocol
// is compared against events observed on the DUT outputs. Honours CHECKSUM_EN like the design.
module tb_uart_frame_loader;
    localparam int         AW      = 3;
    localparam int         DEPTH   = 8;
    localparam int         TIMEOUT = 20;
    localparam logic [7:0] SYNC    = 8'hA5;

    // Event kinds: 0 write, 1 timeout, 2/3 ready rise/fall, 4/5 overrun rise/fall, 6 en/we split, 7/8 chk rise/fall
    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          frame_ack = 1'b0;
    logic          ram_en, ram_we, frame_ready, overrun, timeout, chk_err;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;

    int  cyc = 0;
    int  vectors = 0;
    int  fails = 0;
    ev_t act_q[$];
    ev_t exp_q[$];
    logic rdy_prev = 1'b0, ovr_prev = 1'b0, chk_prev = 1'b0;

    int         m_mode = 0;
    int         m_count = 0;
    int         m_last = 0;
    int         m_rdy_cyc = 0;
    int         m_ovr_cyc = 0;
    int         m_chk_cyc = 0;
    bit         m_ovr = 0;
    bit         m_chk = 0;
    logic [7:0] m_xor = 8'h00;

    uart_frame_loader #(
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .SYNC_BYTE(SYNC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_ack(frame_ack),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .frame_ready(frame_ready),
        .overrun(overrun),
        .timeout(timeout),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int c, int k, int v);
        ev_t e;
        e.cyc = c;
        e.kind = k;
        e.val = v;
        return e;
    endfunction

    // Observed events are sampled mid-cycle, stamped with the cycle they are visible in.
    always @(negedge clk) begin
        if (ram_we || ram_en)
            act_q.push_back(mk(cyc, (ram_we && ram_en) ? 0 : 6, int'(ram_addr) * 256 + int'(ram_din)));
        if (timeout) act_q.push_back(mk(cyc, 1, 0));
        if (frame_ready !== rdy_prev) act_q.push_back(mk(cyc, frame_ready ? 2 : 3, 0));
        if (overrun !== ovr_prev) act_q.push_back(mk(cyc, overrun ? 4 : 5, 0));
        if (chk_err !== chk_prev) act_q.push_back(mk(cyc, chk_err ? 7 : 8, 0));
        rdy_prev <= frame_ready;
        ovr_prev <= overrun;
        chk_prev <= chk_err;
    end

    function automatic void add_exp(int c, int k, int v);
        int i = exp_q.size();
        while (i > 0 && (exp_q[i-1].cyc * 16 + exp_q[i-1].kind) > (c * 16 + k)) i--;
        exp_q.insert(i, mk(c, k, v));
    endfunction

    // Model: a frame aborts once more than TIMEOUT cycles pass after the last accepted byte.
    function automatic void m_expire(int k);
        if ((m_mode == 1 || m_mode == 2) && k > m_last + TIMEOUT) begin
            add_exp(m_last + TIMEOUT + 1, 1, 0);
            m_mode = 0;
        end
    endfunction

    function automatic void m_byte(int k, logic [7:0] b);
        m_expire(k);
        case (m_mode)
            0: if (b == SYNC) begin
                m_mode = 1; m_count = 0; m_last = k; m_xor = 8'h00;
            end
            1: begin
                add_exp(k + 1, 0, m_count * 256 + int'(b));
                m_count++;
                m_xor = m_xor ^ b;
                m_last = k;
                if (m_count == DEPTH) begin
`ifdef CHECKSUM_EN
                    m_mode = 2;
`else
                    m_mode = 3;
                    m_rdy_cyc = k + 2;
                    add_exp(k + 2, 2, 0);
`endif
                end
            end
            2: begin
                m_mode = 3;
                m_rdy_cyc = k + 1;
                add_exp(k + 1, 2, 0);
                if (b != m_xor) begin
                    m_chk = 1; m_chk_cyc = k + 1;
                    add_exp(k + 1, 7, 0);
                end
            end
            default: if (!m_ovr) begin
                m_ovr = 1; m_ovr_cyc = k + 1;
                add_exp(k + 1, 4, 0);
            end
        endcase
    endfunction

    function automatic void m_ack(int k, bit wb, logic [7:0] b);
        m_expire(k);
        if (m_mode == 3 && k >= m_rdy_cyc) begin
            add_exp(k + 1, 3, 0);
            if (m_ovr) add_exp(k + 1, 5, 0);
            if (m_chk) add_exp(k + 1, 8, 0);
            m_mode = 0; m_ovr = 0; m_chk = 0;
        end else if (wb) begin
            m_byte(k, b);
        end
    endfunction

    function automatic void m_reset(int k);
        m_expire(k);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= k) exp_q.delete(exp_q.size() - 1);
        if (m_mode == 3 && m_rdy_cyc < k) add_exp(k, 3, 0);
        if (m_ovr && m_ovr_cyc < k) add_exp(k, 5, 0);
        if (m_chk && m_chk_cyc < k) add_exp(k, 8, 0);
        m_mode = 0; m_ovr = 0; m_chk = 0;
    endfunction

    function automatic int seen_count(int now);
        int n = 0;
        while (n < exp_q.size() && exp_q[n].cyc < now) n++;
        return n;
    endfunction

    function automatic int first_diff(int now);
        int n = seen_count(now);
        int total = (n > act_q.size()) ? n : act_q.size();
        for (int i = 0; i < total; i++) begin
            if (i >= n || i >= act_q.size()) return i;
            if (act_q[i].cyc != exp_q[i].cyc || act_q[i].kind != exp_q[i].kind || act_q[i].val != exp_q[i].val)
                return i;
        end
        return -1;
    endfunction

    function automatic string ev_desc(ev_t e);
        string nm;
        case (e.kind)
            0: nm = "write"; 1: nm = "timeout"; 2: nm = "ready_rise"; 3: nm = "ready_fall";
            4: nm = "ovr_rise"; 5: nm = "ovr_fall"; 6: nm = "en_we_split"; 7: nm = "chk_rise";
            default: nm = "chk_fall";
        endcase
        return $sformatf("cyc%0d:%s:addr%0d:data%02h", e.cyc, nm, e.val / 256, e.val % 256);
    endfunction

    function automatic string act_desc(int i);
        return (i < act_q.size()) ? ev_desc(act_q[i]) : "none";
    endfunction

    function automatic string exp_desc(int i, int now);
        return (i < seen_count(now)) ? ev_desc(exp_q[i]) : "none";
    endfunction

    function automatic void drop_seen(int now);
        while (exp_q.size() > 0 && exp_q[0].cyc < now) exp_q.delete(0);
        act_q.delete();
    endfunction

    function automatic logic [7:0] rnd_byte();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [7:0] rnd_nonsync();
        logic [7:0] b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        m_byte(cyc, b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_ack(input bit wb, input logic [7:0] b);
        m_ack(cyc, wb, b);
        frame_ack = 1'b1;
        rx_valid = wb;
        rx_data = b;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit fixed, input int gapmax, input bit bad_ck);
        logic [7:0] b;
        logic [7:0] ck = 8'h00;
        send_byte(SYNC);
        for (int i = 0; i < DEPTH; i++) begin
            b = fixed ? 8'(i + 1) : rnd_byte();
            ck = ck ^ b;
            send_byte(b);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
`ifdef CHECKSUM_EN
        send_byte(bad_ck ? (fixed ? 8'hFF : ~ck) : ck);
`else
        if (bad_ck) ck = 8'h00;
`endif
    endtask

    task automatic test_reset();
        int d;
        rst_n = 1'b0;
        rx_valid = 1'b1;
        rx_data = SYNC;
        idle(3);
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_din, frame_ready, overrun, timeout, chk_err} !== 17'd0) begin
            $display("[TB] FAIL reset_outputs: got %b, required all zero",
                     {ram_en, ram_we, ram_addr, ram_din, frame_ready, overrun, timeout, chk_err});
            fails++;
        end
        rx_valid = 1'b0;
        rst_n = 1'b1;
        idle(3);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL reset_events: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
    endtask

    task automatic test_basic_frame();
        int d;
        for (int f = 0; f < 2; f++) begin
            send_frame(f == 0, 0, 0);
            idle(3);
            vectors++;
            if (frame_ready !== 1'b1 || chk_err !== 1'b0) begin
                $display("[TB] FAIL basic_ready: got ready=%b chk=%b, required ready=1 chk=0", frame_ready, chk_err);
                fails++;
            end
            send_ack(0, 8'h00);
            vectors++;
            if (frame_ready !== 1'b0) begin
                $display("[TB] FAIL basic_ack: got ready=%b, required 0", frame_ready);
                fails++;
            end
            idle(1);
            m_expire(cyc);
            vectors++;
            d = first_diff(cyc);
            if (d >= 0) begin
                $display("[TB] FAIL basic_events: got %s, required %s", act_desc(d), exp_desc(d, cyc));
                fails++;
            end
            drop_seen(cyc);
        end
    endtask

    task automatic test_hunt_noise();
        int d;
        repeat ($urandom_range(2, 5)) begin
            send_byte(rnd_nonsync());
            idle($urandom_range(0, 2));
        end
        send_ack(1, rnd_nonsync());
        send_frame(0, 3, 0);
        idle(3);
        send_ack(0, 8'h00);
        idle(2);
        m_expire(cyc);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL hunt_events: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
    endtask

    task automatic test_overrun();
        int d;
        send_frame(0, 0, 0);
        idle(2);
        send_byte(SYNC);
        send_byte(rnd_byte());
        vectors++;
        if (overrun !== 1'b1 || frame_ready !== 1'b1) begin
            $display("[TB] FAIL overrun_set: got ovr=%b ready=%b, required ovr=1 ready=1", overrun, frame_ready);
            fails++;
        end
        // Byte coincident with ack must be dropped: it is a sync byte, yet no frame may start.
        send_ack(1, SYNC);
        vectors++;
        if (overrun !== 1'b0 || frame_ready !== 1'b0) begin
            $display("[TB] FAIL overrun_clear: got ovr=%b ready=%b, required 0 0", overrun, frame_ready);
            fails++;
        end
        repeat (4) send_byte(rnd_nonsync());
        idle(2);
        m_expire(cyc);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL overrun_events: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
    endtask

    task automatic test_timeout();
        int d;
        send_byte(SYNC);
        repeat (3) send_byte(rnd_byte());
        idle(TIMEOUT + 5);
        m_expire(cyc);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL timeout_abort: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
        vectors++;
        if (timeout !== 1'b0 || frame_ready !== 1'b0) begin
            $display("[TB] FAIL timeout_idle: got to=%b ready=%b, required 0 0", timeout, frame_ready);
            fails++;
        end
        // Longest legal gap keeps the frame; one more idle cycle aborts it.
        send_byte(SYNC);
        send_byte(rnd_byte());
        idle(TIMEOUT - 1);
        send_byte(rnd_byte());
        idle(TIMEOUT);
        send_byte(rnd_nonsync());
        send_frame(0, 0, 0);
        idle(3);
        send_ack(0, 8'h00);
        idle(2);
        m_expire(cyc);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL timeout_boundary: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
    endtask

    task automatic test_reset_mid_frame();
        int d;
        send_byte(SYNC);
        repeat (4) send_byte(rnd_byte());
        m_reset(cyc);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_din, frame_ready, overrun, timeout, chk_err} !== 17'd0) begin
            $display("[TB] FAIL midreset_outputs: got %b, required all zero",
                     {ram_en, ram_we, ram_addr, ram_din, frame_ready, overrun, timeout, chk_err});
            fails++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_frame(0, 0, 0);
        idle(3);
        send_ack(0, 8'h00);
        idle(2);
        m_expire(cyc);
        vectors++;
        d = first_diff(cyc);
        if (d >= 0) begin
            $display("[TB] FAIL midreset_events: got %s, required %s", act_desc(d), exp_desc(d, cyc));
            fails++;
        end
        drop_seen(cyc);
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        for (int bad = 0; bad < 2; bad++) begin
            send_frame(1, 0, bad != 0);
            idle(3);
            vectors++;
            if (frame_ready !== 1'b1 || chk_err !== (bad != 0)) begin
                $display("[TB] FAIL checksum_flag: got ready=%b chk=%b, required ready=1 chk=%0d",
                         frame_ready, chk_err, bad);
                fails++;
            end
            send_ack(0, 8'h00);
            idle(2);
        end
    endtask
`endif

    task automatic test_random();
        int d;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) begin
                send_byte(rnd_nonsync());
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 1) send_ack(1, rnd_nonsync());
            if ($urandom_range(0, 2) == 0) begin
                send_byte(SYNC);
                repeat ($urandom_range(0, DEPTH - 1)) send_byte(rnd_byte());
                idle(TIMEOUT + $urandom_range(1, 4));
            end
            send_frame(0, ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : 2, $urandom_range(0, 1) == 1);
            idle(3);
            repeat ($urandom_range(0, 2)) send_byte(rnd_byte());
            idle($urandom_range(0, 2));
            send_ack($urandom_range(0, 1) == 1, rnd_byte());
            idle(2);
            m_expire(cyc);
            vectors++;
            d = first_diff(cyc);
            if (d >= 0) begin
                $display("[TB] FAIL random_events it%0d: got %s, required %s", it, act_desc(d), exp_desc(d, cyc));
                fails++;
            end
            drop_seen(cyc);
            vectors++;
            if (frame_ready !== 1'b0 || overrun !== 1'b0 || chk_err !== 1'b0) begin
                $display("[TB] FAIL random_idle it%0d: got ready=%b ovr=%b chk=%b, required 0 0 0",
                         it, frame_ready, overrun, chk_err);
                fails++;
            end
        end
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_hunt_noise();
        test_overrun();
        test_timeout();
        test_reset_mid_frame();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
